// File: rtl/jtcps1_gfx_req.sv
// -----------------------------------------------------------------------------
// jtcps1_gfx_req
//
// Tile-fetch front end for the CPS1 GFX ROM. It accepts one request at a time
// from the OBJ/SCROLL/STAR engines. It presents {layer, code[15:6]} to the bank
// mapper and waits out the mapper's registered latency. It then either issues a
// ROM word read or answers with a transparent word for unmapped codes. A
// one-entry mapping cache lets a repeated tile skip the mapper wait.
//
// Parameters
//   MAP_LAT  cycles from mapper input change to valid offset/mask/unmapped (>=1)
//   BLANK    word returned for unmapped codes (pen 15 = transparent)
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   flush             invalidates the mapping cache (one-cycle pulse)
//   req, layer,       request strobe (sampled only while busy=0), layer id,
//   code, sub         tile code, word offset within the tile
//   busy              request in progress
//   data_ok, data     one-cycle valid pulse and returned pixel word (held)
//   map_layer,        mapper lookup key
//   map_cin
//   map_offset,       mapper result
//   map_mask,
//   map_unmapped
//   rom_cs, rom_addr  ROM read request (held until rom_ok) and word address
//   rom_ok, rom_data  ROM data valid and read data
// -----------------------------------------------------------------------------
module jtcps1_gfx_req #(
  parameter int          MAP_LAT = 2,
  parameter logic [31:0] BLANK   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req,
  input  logic [2:0]  layer,
  input  logic [15:0] code,
  input  logic [3:0]  sub,
  output logic        busy,
  output logic        data_ok,
  output logic [31:0] data,
  output logic [2:0]  map_layer,
  output logic [9:0]  map_cin,
  input  logic [3:0]  map_offset,
  input  logic [3:0]  map_mask,
  input  logic        map_unmapped,
  output logic        rom_cs,
  output logic [19:0] rom_addr,
  input  logic        rom_ok,
  input  logic [31:0] rom_data
);

  localparam int            CW       = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MAP_LAT - 1);

  typedef enum logic [1:0] {IDLE, MAP, ROM} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Registered outputs: next values
  logic        busy_nxt, data_ok_nxt, rom_cs_nxt;
  logic [31:0] data_nxt;
  logic [2:0]  map_layer_nxt;
  logic [9:0]  map_cin_nxt;
  logic [19:0] rom_addr_nxt;

  // Request being served and, on a hit, the cached mapping captured with it
  logic [15:0] code_q, code_nxt;
  logic [3:0]  sub_q, sub_nxt;
  logic        hit_q, hit_nxt;
  logic [3:0]  h_off, h_off_nxt, h_mask, h_mask_nxt;
  logic        h_unm, h_unm_nxt;

  // One-entry mapping cache
  logic        c_valid, c_valid_nxt;
  logic [2:0]  c_layer, c_layer_nxt;
  logic [9:0]  c_cin, c_cin_nxt;
  logic [3:0]  c_off, c_off_nxt, c_mask, c_mask_nxt;
  logic        c_unm, c_unm_nxt;

  // Mapping used at resolve time and the cache lookup for a new request
  logic [3:0]  r_off, r_mask;
  logic        r_unm;
  logic        lookup_hit;

  // NOTE: every signal assigned below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    busy_nxt      = busy;
    data_ok_nxt   = 1'b0;
    data_nxt      = data;
    map_layer_nxt = map_layer;
    map_cin_nxt   = map_cin;
    rom_cs_nxt    = rom_cs;
    rom_addr_nxt  = rom_addr;
    code_nxt      = code_q;
    sub_nxt       = sub_q;
    hit_nxt       = hit_q;
    h_off_nxt     = h_off;
    h_mask_nxt    = h_mask;
    h_unm_nxt     = h_unm;
    c_valid_nxt   = c_valid;
    c_layer_nxt   = c_layer;
    c_cin_nxt     = c_cin;
    c_off_nxt     = c_off;
    c_mask_nxt    = c_mask;
    c_unm_nxt     = c_unm;

    // A hit resolves from the mapping captured at request time, so a later
    // flush cannot change an in-flight request.
    r_off  = hit_q ? h_off  : map_offset;
    r_mask = hit_q ? h_mask : map_mask;
    r_unm  = hit_q ? h_unm  : map_unmapped;

    // A flush in the same cycle already makes the entry unusable.
    lookup_hit = c_valid && !flush && (c_layer == layer) && (c_cin == code[15:6]);

    case (state)
      IDLE: begin
        if (req) begin
          map_layer_nxt = layer;
          map_cin_nxt   = code[15:6];
          code_nxt      = code;
          sub_nxt       = sub;
          busy_nxt      = 1'b1;
          hit_nxt       = lookup_hit;
          h_off_nxt     = c_off;
          h_mask_nxt    = c_mask;
          h_unm_nxt     = c_unm;
          // A hit still spends one cycle in MAP, giving the fixed E0+1 timing.
          cnt_nxt       = lookup_hit ? '0 : CNT_LOAD;
          state_nxt     = MAP;
        end
      end

      MAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          if (!hit_q) begin
            c_valid_nxt = 1'b1;
            c_layer_nxt = map_layer;
            c_cin_nxt   = map_cin;
            c_off_nxt   = map_offset;
            c_mask_nxt  = map_mask;
            c_unm_nxt   = map_unmapped;
          end
          if (r_unm) begin
            data_ok_nxt = 1'b1;
            data_nxt    = BLANK;
            busy_nxt    = 1'b0;
            state_nxt   = IDLE;
          end else begin
            rom_addr_nxt = {(code_q[15:12] & r_mask) | r_off, code_q[11:0], sub_q};
            rom_cs_nxt   = 1'b1;
            state_nxt    = ROM;
          end
        end
      end

      ROM: begin
        if (rom_ok) begin
          rom_cs_nxt  = 1'b0;
          data_nxt    = rom_data;
          data_ok_nxt = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Applied last so a flush on the cache-write edge leaves the entry invalid.
    if (flush) c_valid_nxt = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      data_ok   <= 1'b0;
      data      <= '0;
      map_layer <= '0;
      map_cin   <= '0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      c_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      data_ok   <= data_ok_nxt;
      data      <= data_nxt;
      map_layer <= map_layer_nxt;
      map_cin   <= map_cin_nxt;
      rom_cs    <= rom_cs_nxt;
      rom_addr  <= rom_addr_nxt;
      c_valid   <= c_valid_nxt;
    end
  end

  // NOTE: cache payload and request latches carry no reset; they are only
  // read while c_valid or the FSM says they hold live data.
  always_ff @(posedge clk) begin
    code_q  <= code_nxt;
    sub_q   <= sub_nxt;
    hit_q   <= hit_nxt;
    h_off   <= h_off_nxt;
    h_mask  <= h_mask_nxt;
    h_unm   <= h_unm_nxt;
    c_layer <= c_layer_nxt;
    c_cin   <= c_cin_nxt;
    c_off   <= c_off_nxt;
    c_mask  <= c_mask_nxt;
    c_unm   <= c_unm_nxt;
  end

endmodule
